fir_decimator: RTL
==================

Name: fir_decimator

Overview:
- Integrate-and-dump decimator directly downstream of the FIR stage.
- Consumes the FIR's signed output samples and sums D = 2^DECIM_LOG2 accepted samples per window.
- Emits one rounded and saturated sample per window with a single-cycle valid strobe.
- Reduces output rate so the result can be observed on the 8-bit pin bus at a slower cadence.

Parameters:
- BW_in, 8: FIR output sample width, signed.
- DECIM_LOG2, 2: log2 of the decimation factor D; legal range 1..4.
- BW_out, 8: output sample width, signed; legal range 2..BW_in+DECIM_LOG2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- x_in  in  BW_in  signed FIR sample.
- x_valid  in  1  x_in is accepted this cycle; tie high for a continuous FIR stream.
- restart  in  1  synchronous window restart.
- y_out  out  BW_out  signed decimated sample, held between strobes.
- y_valid  out  1  one-cycle strobe; y_out was updated this cycle.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: y_out=0, y_valid=0, acc=0, phase=0.
- Reset mid-window discards the partial sum.
- Internal state:
  - acc, signed, BW_acc = BW_in+DECIM_LOG2 bits.
  - phase counter, DECIM_LOG2 bits.
- Two-state FSM:
  - ACCUM: default. On x_valid: if phase < D-1, acc <= acc + x_in and phase++.
  - DUMP, taken when phase = D-1 and x_valid: S = acc + sign-extended x_in; y_out <= rs(S); acc <= 0; phase <= 0; y_valid <= 1 next cycle; return to ACCUM.
  - DUMP occupies no extra cycle; sample D+1 is accepted in the cycle immediately after sample D.
- Latency: y_valid and y_out appear on the clock edge that registers sample D, i.e. visible in the cycle after sample D is presented.
- y_valid is 0 in every other cycle. y_out holds its value otherwise.
- x_valid=0: acc and phase hold. Gaps do not affect the result.
- restart=1:
  - acc <= 0 and phase <= 0, no output produced.
  - If x_valid is also 1, that sample is taken as the first of the new window: acc <= x_in, phase <= 1.
  - restart overrides DUMP in the same cycle; no y_valid.
- rs(S), with SH = BW_acc - BW_out:
  - SH=0: result is S.
  - SH>0, truncation: arithmetic shift S >>> SH.
  - Rounding when enabled: add 2^(SH-1), using one extra guard bit, then shift.
  - Saturation: result clamped to [-2^(BW_out-1), 2^(BW_out-1)-1].
  - Overflow is only reachable when BW_out < BW_in, but the clamp is always present.
- No internal wrap: BW_acc covers D × full-scale exactly.

Optional Feature:
- Macro FIR_DECIM_ROUND_EN.
- Defined: round-half-up, i.e. add 2^(SH-1) before the arithmetic shift, then saturate.
- Undefined: truncation toward -inf, then saturate.
- When SH=0 the macro has no effect.

Decomposition:
- Shared package ttfir_pkg holds:
  - Default widths BW_IN=6 (FIR input), BW_FIR_OUT=8, DECIM_LOG2=2.
  - The FSM state enum {ACCUM, DUMP}.
  - A width helper function returning BW_acc.
- One sub-module, fir_decim_round_sat: combinational shift/round/clamp from BW_acc to BW_out, with the FIR_DECIM_ROUND_EN switch inside.
- Top holds the FSM, phase counter and accumulator.

Test Plan:
1. Defaults, x_valid=1, x_in=5 for 4 cycles -> y_valid pulses once after the 4th sample, y_out=5; repeats every 4 cycles.
2. Samples 1,1,1,0 -> sum 3; y_out=0 without FIR_DECIM_ROUND_EN, y_out=1 with it.
3. Full scale: 127×4 -> y_out=127; -128×4 -> y_out=-128. Override BW_out=6 with ROUND_EN: 127×4 -> (508+8)>>4 = 32 -> saturated y_out=31.
4. x_valid pattern 1,0,0,1,0,1,1 with x_in=8 -> exactly one y_valid, one cycle after the last valid sample, y_out=8.
5. Two samples of 20, then restart=1 with x_valid=1, x_in=4, then 4,4,4 -> no strobe at restart; next y_out=4.
6. Assert rst_n low asynchronously mid-window (between clock edges) -> y_out=0, y_valid=0 immediately. After release, 4 samples of -3 -> y_out=-3.

Source files
------------

// File: rtl/ttfir_pkg.sv
// -----------------------------------------------------------------------------
// ttfir_pkg
//   Shared definitions for the FIR chain and its integrate-and-dump decimator:
//   default datapath widths, the decimator FSM state type and a helper that
//   sizes the decimator accumulator.
//
//   Contents:
//     BW_IN        FIR input sample width
//     BW_FIR_OUT   FIR output sample width (decimator input width)
//     DECIM_LOG2   log2 of the default decimation factor
//     decim_state_e  {ACCUM, DUMP}
//     acc_width()    accumulator width that holds D full-scale samples exactly
// -----------------------------------------------------------------------------
package ttfir_pkg;

   localparam int BW_IN      = 6;
   localparam int BW_FIR_OUT = 8;
   localparam int DECIM_LOG2 = 2;

   // ACCUM: window still collecting samples.
   // DUMP : the next accepted sample closes the window.
   typedef enum logic {
      ACCUM = 1'b0,
      DUMP  = 1'b1
   } decim_state_e;

   // D samples of a bw_in-bit signed value need exactly decim_log2 extra bits:
   // D * -2^(bw_in-1) = -2^(bw_in+decim_log2-1) is the most negative sum.
   function automatic int acc_width(input int bw_in, input int decim_log2);
      return bw_in + decim_log2;
   endfunction

endpackage

// File: rtl/fir_decim_round_sat.sv
// -----------------------------------------------------------------------------
// fir_decim_round_sat
//   Combinational rescale of a window sum from BW_ACC to BW_OUT bits:
//   arithmetic right shift by SH = BW_ACC - BW_OUT, optional round-half-up,
//   then clamp to the signed BW_OUT range.
//
//   Build option:
//     FIR_DECIM_ROUND_EN  defined   -> add 2^(SH-1) before the shift
//                         undefined -> plain truncation toward -inf
//     With SH = 0 the option has no effect.
//
//   Ports:
//     i_sum  in   BW_ACC  signed window sum
//     o_y    out  BW_OUT  signed rescaled, saturated sample
// -----------------------------------------------------------------------------
module fir_decim_round_sat #(
   parameter int BW_ACC = 10,
   parameter int BW_OUT = 8
) (
   input  logic signed [BW_ACC-1:0] i_sum,
   output logic signed [BW_OUT-1:0] o_y
);

   localparam int SH     = BW_ACC - BW_OUT;
   // One guard bit so the rounding bias can never wrap the sum.
   localparam int BW_EXT = BW_ACC + 1;

   localparam int Y_MAX_I = (1 << (BW_OUT - 1)) - 1;
   localparam int Y_MIN_I = -Y_MAX_I - 1;

   localparam logic signed [BW_EXT-1:0] Y_MAX_EXT = BW_EXT'(Y_MAX_I);
   localparam logic signed [BW_EXT-1:0] Y_MIN_EXT = BW_EXT'(Y_MIN_I);
   localparam logic signed [BW_OUT-1:0] Y_MAX_OUT = BW_OUT'(Y_MAX_I);
   localparam logic signed [BW_OUT-1:0] Y_MIN_OUT = BW_OUT'(Y_MIN_I);

   logic signed [BW_EXT-1:0] w_ext;
   logic signed [BW_EXT-1:0] w_shifted;

   assign w_ext = {i_sum[BW_ACC-1], i_sum};

   generate
      if (SH > 0) begin : g_shift
         logic signed [BW_EXT-1:0] w_biased;
`ifdef FIR_DECIM_ROUND_EN
         localparam logic signed [BW_EXT-1:0] ROUND_BIAS = BW_EXT'(1) << (SH - 1);
         assign w_biased = w_ext + ROUND_BIAS;
`else
         assign w_biased = w_ext;
`endif
         assign w_shifted = w_biased >>> SH;
      end else begin : g_pass
         assign w_shifted = w_ext;
      end
   endgenerate

   // Clamp is kept even where the range cannot overflow; it costs nothing
   // when the comparisons are constant-false and protects narrow BW_OUT.
   always_comb begin
      // NOTE: assign a default first so every path drives o_y and no latch
      // is inferred.
      o_y = w_shifted[BW_OUT-1:0];
      if (w_shifted > Y_MAX_EXT) begin
         o_y = Y_MAX_OUT;
      end else if (w_shifted < Y_MIN_EXT) begin
         o_y = Y_MIN_OUT;
      end
   end

endmodule

// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
//   Integrate-and-dump decimator placed after the FIR stage. Sums
//   D = 2^DECIM_LOG2 accepted samples, then emits one rescaled, saturated
//   sample with a one-cycle strobe. The window closes without a bubble: the
//   first sample of the next window is accepted in the very next cycle.
//
//   Build option: FIR_DECIM_ROUND_EN selects round-half-up instead of
//   truncation in the output rescale (see fir_decim_round_sat).
//
//   Ports:
//     clk      in   1       system clock, rising edge
//     rst_n    in   1       asynchronous reset, active-low
//     x_in     in   BW_in   signed FIR sample
//     x_valid  in   1       x_in accepted this cycle
//     restart  in   1       synchronous window restart (beats a pending dump)
//     y_out    out  BW_out  signed decimated sample, held between strobes
//     y_valid  out  1       one-cycle strobe, y_out updated this cycle
// -----------------------------------------------------------------------------
module fir_decimator #(
   parameter int BW_in      = ttfir_pkg::BW_FIR_OUT,
   parameter int DECIM_LOG2 = ttfir_pkg::DECIM_LOG2,
   parameter int BW_out     = ttfir_pkg::BW_FIR_OUT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [BW_in-1:0]  x_in,
   input  logic                     x_valid,
   input  logic                     restart,
   output logic signed [BW_out-1:0] y_out,
   output logic                     y_valid
);

   import ttfir_pkg::*;

   localparam int BW_ACC = acc_width(BW_in, DECIM_LOG2);
   localparam int D      = 1 << DECIM_LOG2;

   localparam logic [DECIM_LOG2-1:0] PHASE_ONE  = DECIM_LOG2'(1);
   localparam logic [DECIM_LOG2-1:0] PHASE_PRE  = DECIM_LOG2'(D - 2);
   localparam logic [DECIM_LOG2-1:0] PHASE_LAST = DECIM_LOG2'(D - 1);

   // After a restart with a valid sample the window already holds one
   // sample; for D = 2 that sample leaves only the closing one to go.
   localparam decim_state_e RESTART_STATE = (PHASE_ONE == PHASE_LAST) ? DUMP : ACCUM;

   decim_state_e             r_state;
   logic [DECIM_LOG2-1:0]    r_phase;
   logic signed [BW_ACC-1:0] r_acc;
   logic signed [BW_out-1:0] r_y_out;
   logic                     r_y_valid;

   logic signed [BW_ACC-1:0] w_x_ext;
   logic signed [BW_ACC-1:0] w_sum;
   logic signed [BW_out-1:0] w_y_rs;

   assign w_x_ext = {{DECIM_LOG2{x_in[BW_in-1]}}, x_in};
   assign w_sum   = r_acc + w_x_ext;

   fir_decim_round_sat #(
      .BW_ACC (BW_ACC),
      .BW_OUT (BW_out)
   ) u_round_sat (
      .i_sum (w_sum),
      .o_y   (w_y_rs)
   );

   // r_state is DUMP exactly when r_phase == D-1; it names the closing step
   // so the dump branch does not re-decode the phase counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ACCUM;
         r_phase   <= '0;
         r_acc     <= '0;
         r_y_out   <= '0;
         r_y_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all state so every register
         // samples pre-edge values regardless of statement order.
         r_y_valid <= 1'b0;
         if (restart) begin
            if (x_valid) begin
               r_acc   <= w_x_ext;
               r_phase <= PHASE_ONE;
               r_state <= RESTART_STATE;
            end else begin
               r_acc   <= '0;
               r_phase <= '0;
               r_state <= ACCUM;
            end
         end else if (x_valid) begin
            case (r_state)
               ACCUM: begin
                  r_acc   <= w_sum;
                  r_phase <= r_phase + PHASE_ONE;
                  if (r_phase == PHASE_PRE) begin
                     r_state <= DUMP;
                  end
               end
               DUMP: begin
                  r_y_out   <= w_y_rs;
                  r_y_valid <= 1'b1;
                  r_acc     <= '0;
                  r_phase   <= '0;
                  r_state   <= ACCUM;
               end
               default: begin
                  r_state <= ACCUM;
               end
            endcase
         end
      end
   end

   assign y_out   = r_y_out;
   assign y_valid = r_y_valid;

endmodule
